// File: rtl/ds_reg_ctrl.sv
// Parameter-register controller for the delta-sigma modulator.
// Assembles byte commands into 16-bit shadow writes and commits all shadow
// registers to the active set atomically on a programmable sample tick.
module ds_reg_ctrl #(
  parameter int unsigned NUM_REGS  = 3,
  parameter int unsigned REG_BITS  = 16,
  parameter int unsigned DIV_BITS  = 8,
  parameter int unsigned DIV_RESET = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         sample_tick,
  output logic [NUM_REGS*REG_BITS-1:0] regs,
  output logic                         update,
  output logic                         err
);

  typedef enum logic [1:0] {StIdle, StDataLo, StDataHi, StDivByte} state_e;

  localparam logic [DIV_BITS-1:0] DivInit = DIV_BITS'(DIV_RESET);

  state_e              state_q, state_d;
  logic [4:0]          addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;
  logic [REG_BITS-1:0] shadow_q [NUM_REGS];
  logic [REG_BITS-1:0] shadow_d [NUM_REGS];
  logic [REG_BITS-1:0] active_q [NUM_REGS];
  logic [REG_BITS-1:0] active_d [NUM_REGS];
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic                update_q, update_d;
  logic                err_q, err_d;
  logic                pending_q, pending_d;

  logic accept;
  logic tick_now;
  logic addr_hit;

  // Bytes are held off while a commit waits for its tick.
  assign in_ready    = !pending_q;
  assign accept      = in_valid && !pending_q;
  assign tick_now    = (cnt_q == '0);
  assign sample_tick = tick_q;
  assign update      = update_q;
  assign err         = err_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*REG_BITS +: REG_BITS] = active_q[g];
  end

  // Next-state: divider, commit, and command FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    update_d  = 1'b0;
    err_d     = err_q;
    pending_d = pending_q;
    addr_hit  = 1'b0;

    if (tick_now) begin
      cnt_d  = div_q;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q - 1'b1;
    end

    // Only a commit already pending before this edge may fire here.
    if (tick_now && pending_q) begin
      active_d  = shadow_q;
      update_d  = 1'b1;
      pending_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          unique case (in_data[7:6])
            2'b00: begin
              addr_d  = in_data[4:0];
              state_d = StDataLo;
            end
            2'b01:   state_d   = StDivByte;
            2'b10:   pending_d = 1'b1;
            default: err_d     = 1'b0;
          endcase
        end
        StDataLo: begin
          lo_d    = in_data;
          state_d = StDataHi;
        end
        StDataHi: begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(addr_q) == i) begin
              shadow_d[i] = REG_BITS'({in_data, lo_q});
              addr_hit    = 1'b1;
            end
          end
          if (!addr_hit) err_d = 1'b1;
          state_d = StIdle;
        end
        default: begin
          div_d   = DIV_BITS'(in_data);
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      lo_q      <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      div_q     <= DivInit;
      cnt_q     <= DivInit;
      tick_q    <= 1'b0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      update_q  <= update_d;
      err_q     <= err_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_ds_reg_ctrl.sv
// Bench for ds_reg_ctrl: directed scenarios followed by random byte traffic,
// all checked every cycle against a transaction-level reference model.
module tb_ds_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        sample_tick;
  logic [47:0] regs;
  logic        update;
  logic        err;

  int checks   = 0;
  int failures = 0;

  ds_reg_ctrl #(
    .NUM_REGS (3),
    .REG_BITS (16),
    .DIV_BITS (8),
    .DIV_RESET(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .sample_tick(sample_tick),
    .regs       (regs),
    .update     (update),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 expect low byte, 2 expect high byte, 3 expect divider.
  logic [15:0] m_shadow [3];
  logic [15:0] m_active [3];
  int          m_div, m_cnt, m_phase, m_addr;
  logic [7:0]  m_lo;
  bit          m_tick, m_update, m_err, m_pending;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] m_regs();
    return {m_active[2], m_active[1], m_active[0]};
  endfunction

  task automatic chk_outputs();
    chk("tick", 64'(sample_tick), 64'(m_tick));
    chk("update", 64'(update), 64'(m_update));
    chk("err", 64'(err), 64'(m_err));
    chk("ready", 64'(in_ready), 64'(!m_pending));
    chk("regs", 64'(regs), 64'(m_regs()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_div = 0; m_cnt = 0; m_phase = 0; m_addr = 0; m_lo = '0;
    m_tick = 0; m_update = 0; m_err = 0; m_pending = 0;
  endtask

  // One clock with an optional byte offered; model advances on the same edge.
  task automatic cycle(input bit v, input logic [7:0] d);
    bit acc, tick_now, was_pending;
    in_valid = v;
    in_data  = d;
    #1;
    chk("ready_pre", 64'(in_ready), 64'(!m_pending));
    acc = v && !m_pending;
    @(posedge clk);
    tick_now    = (m_cnt == 0);
    was_pending = m_pending;
    m_tick      = tick_now;
    m_cnt       = tick_now ? m_div : m_cnt - 1;
    m_update    = 0;
    if (tick_now && was_pending) begin
      m_active  = m_shadow;
      m_update  = 1;
      m_pending = 0;
    end
    if (acc) begin
      case (m_phase)
        0: case (d[7:6])
             2'd0: begin m_addr = int'(d[4:0]); m_phase = 1; end
             2'd1: m_phase = 3;
             2'd2: m_pending = 1;
             default: m_err = 0;
           endcase
        1: begin m_lo = d; m_phase = 2; end
        2: begin
          if (m_addr < 3) m_shadow[m_addr] = {d, m_lo};
          else m_err = 1;
          m_phase = 0;
        end
        default: begin m_div = int'(d); m_phase = 0; end
      endcase
    end
    #1;
    chk_outputs();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    model_reset();
    #1;
    chk_outputs();
    rst_n = 1'b1;
  endtask

  // Idle until the model's pending commit fires; bounded.
  task automatic wait_commit();
    int n = 0;
    while (m_pending && n < 600) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("commit_timeout", 64'(m_pending), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_regs", 64'(regs), 64'd0);

    // Divider 0: tick every cycle from the first edge.
    cycle(1'b0, 8'h00);
    chk("tick_first", 64'(sample_tick), 64'd1);
    cycle(1'b0, 8'h00);
    chk("tick_second", 64'(sample_tick), 64'd1);

    // SET_DIV 3, write reg1, commit.
    cycle(1'b1, 8'h40); cycle(1'b1, 8'h03);
    cycle(1'b1, 8'h01); cycle(1'b1, 8'h34); cycle(1'b1, 8'h12);
    cycle(1'b1, 8'h80);
    wait_commit();
    chk("reg1_commit", 64'(regs[31:16]), 64'h1234);
    chk("update_pulse", 64'(update), 64'd1);
    cycle(1'b0, 8'h00);
    chk("update_once", 64'(update), 64'd0);
    repeat (8) cycle(1'b0, 8'h00);

    // Shadow write without commit stays invisible.
    cycle(1'b1, 8'h02); cycle(1'b1, 8'hEF); cycle(1'b1, 8'hBE);
    repeat (12) cycle(1'b0, 8'h00);
    chk("reg2_uncommitted", 64'(regs[47:32]), 64'h0);
    cycle(1'b1, 8'h80);
    wait_commit();
    chk("reg2_commit", 64'(regs[47:32]), 64'hBEEF);

    // Invalid address sets sticky err, CLEAR_ERR drops it.
    cycle(1'b1, 8'h05); cycle(1'b1, 8'hAA); cycle(1'b1, 8'h55);
    chk("err_set", 64'(err), 64'd1);
    repeat (3) cycle(1'b0, 8'h00);
    chk("err_sticky", 64'(err), 64'd1);
    cycle(1'b1, 8'hC0);
    chk("err_clear", 64'(err), 64'd0);

    // COMMIT accepted on the edge where the counter is zero waits a full period.
    for (int n = 0; n < 10 && m_cnt != 0; n++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h80);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00);
      chk("late_no_update", 64'(update), 64'd0);
      chk("late_ready_low", 64'(in_ready), 64'd0);
    end
    cycle(1'b0, 8'h00);
    chk("late_update", 64'(update), 64'd1);
    chk("late_ready_back", 64'(in_ready), 64'd1);

    // Reset mid-WRITE discards the partial transaction.
    cycle(1'b1, 8'h00); cycle(1'b1, 8'h99);
    do_reset();
    cycle(1'b1, 8'h02); cycle(1'b1, 8'h11); cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h80);
    wait_commit();
    chk("post_reset_reg2", 64'(regs[47:32]), 64'h2211);
    chk("post_reset_reg1", 64'(regs[31:16]), 64'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit         v;
      logic [7:0] b;
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom_range(0, 255));
      if (m_phase == 3) b = 8'($urandom_range(0, 5));
      else if (m_phase == 0) b = {b[7:5], 5'($urandom_range(0, 4))};
      cycle(v, b);
    end
    in_valid = 1'b0;
    wait_commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
